game_seq_ctrl: RTL and testbench
================================

GAME_SEQ_CTRL -- requirements
Module: game_seq_ctrl

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 100_000_000: clk cycles per game second (benches use small values, e.g. 8).
REQ-002 SHALL have parameter RESULT_TICKS, default 4: game seconds the RESULT state is held.
REQ-003 SHALL have ports (clock and reset first):
- clk  in  1  sole clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle start/advance pulse, already debounced.
- hit  in  1  single-cycle pulse: a lit target was struck.
- time_cfg  in  8  time limit, 2-digit BCD {tens, ones}.
- goal_cfg  in  8  hit goal, 2-digit BCD {tens, ones}.
- state  out  2  0=IDLE, 1=ARMED, 2=PLAY, 3=RESULT.
- time_bcd  out  8  seconds remaining, BCD.
- hits_bcd  out  8  hits so far, BCD.
- spawn  out  1  single-cycle request for a new target pattern.
- win  out  1  result flag, meaningful in RESULT.
- tick  out  1  single-cycle game-second strobe.

Function
REQ-004 SHALL use a 4-state FSM: IDLE, ARMED, PLAY, RESULT; state output is the registered FSM state.
REQ-005 IDLE: start -> ARMED. hit is ignored.
REQ-006 ARMED: start -> PLAY. On that same edge:
- time counter <= time_cfg (clamped); goal register <= goal_cfg (clamped).
- hits <= 0; tick counter <= 0.
REQ-007 Clamping: any BCD digit of time_cfg or goal_cfg greater than 9 SHALL be loaded as 9.
REQ-008 In IDLE and ARMED, time_bcd and hits_bcd SHALL show the clamped time_cfg and goal_cfg combinationally; in PLAY and RESULT they SHALL show the counters.
REQ-009 Tick counter:
- counts 0..TICK_CYCLES-1 in PLAY and RESULT only; held at 0 otherwise.
- tick=1 in the cycle the counter equals TICK_CYCLES-1, after which it wraps to 0.
REQ-010 PLAY, on tick with time counter nonzero: BCD decrement (e.g. 0x10 -> 0x09); never below 0x00.
REQ-011 PLAY, on hit: hits += 1 in BCD (0x09 -> 0x10); saturate at 0x99.
REQ-012 Simultaneous hit and tick in one cycle: both updates SHALL apply.
REQ-013 PLAY exit, evaluated on registered values each cycle:
- hits == goal -> RESULT with win=1.
- otherwise, time == 0 -> RESULT with win=0.
- If both hold, win=1 has priority.
REQ-014 Boundary cases:
- goal_cfg = 0x00: exit with win=1 on the first PLAY cycle.
- time_cfg = 0x00 with nonzero goal: exit with win=0 on the first PLAY cycle.
REQ-015 spawn SHALL pulse:
- in the first PLAY cycle;
- on every tick in PLAY in the same cycle as the exit test fails.
- It SHALL NOT pulse in any other state.
REQ-016 RESULT: freeze time and hits; ignore hit and start; count ticks; on the RESULT_TICKS-th tick -> IDLE.
REQ-017 win SHALL be set on PLAY->RESULT, held through RESULT, and cleared on entry to IDLE.
REQ-018 start SHALL be ignored in PLAY and RESULT.
REQ-019 Counters SHALL hold when not explicitly updated.

Reset
REQ-020 rst=1 at a clock edge SHALL force, from any state including mid-PLAY:
- state=IDLE; time, hits, goal and tick counters = 0.
- win=0; spawn=0; tick=0.
REQ-021 rst SHALL take priority over start, hit and tick in the same cycle.
REQ-022 With rst asserted, outputs SHALL show IDLE values on the following cycle.

Verification
REQ-023 Bench SHALL cover these directed scenarios (TICK_CYCLES=8, RESULT_TICKS=4):
- Normal win: time_cfg=0x05, goal_cfg=0x03, start, start, 3 hits within 2 ticks -> RESULT, win=1, hits_bcd=0x03, time_bcd=0x04 or 0x03; IDLE after 32 cycles in RESULT.
- Timeout: time_cfg=0x02, goal_cfg=0x05, no hits -> time_bcd 0x02->0x01->0x00; RESULT, win=0 after 16 cycles; spawn count=2.
- BCD and saturation: time_cfg=0x12 -> after 3 ticks time_bcd=0x09; 99 hits then 1 more -> hits_bcd=0x99.
- Simultaneous events: hit in the tick cycle reaching goal when time=0x01 -> win=1.
- Clamp and zero: time_cfg=0x3F -> loads 0x39; goal_cfg=0x00 -> RESULT, win=1 on the cycle after PLAY entry.
- Reset mid-PLAY: rst during PLAY with hits=0x02 -> next cycle state=0, hits_bcd shows goal_cfg, win=0, no spawn.

Source files
------------

// File: rtl/game_seq_ctrl.sv
// Reaction-game sequencer: IDLE -> ARMED -> PLAY -> RESULT -> IDLE.
// Keeps the BCD countdown timer and hit counter and paces the game in ticks.
module game_seq_ctrl #(
    parameter int TICK_CYCLES  = 100_000_000,
    parameter int RESULT_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       hit,
    input  logic [7:0] time_cfg,
    input  logic [7:0] goal_cfg,
    output logic [1:0] state,
    output logic [7:0] time_bcd,
    output logic [7:0] hits_bcd,
    output logic       spawn,
    output logic       win,
    output logic       tick
);

    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int RW = (RESULT_TICKS > 1) ? $clog2(RESULT_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [RW-1:0] RES_LAST  = RW'(RESULT_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ARMED  = 2'd1,
        S_PLAY   = 2'd2,
        S_RESULT = 2'd3
    } state_e;

    function automatic logic [7:0] clamp_bcd(input logic [7:0] v);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = (v[7:4] > 4'd9) ? 4'd9 : v[7:4];
        ones = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
        return {tens, ones};
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h99) begin
            r = v;
        end else if (v[3:0] >= 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h00) begin
            r = v;
        end else if (v[3:0] == 4'd0) begin
            r = {v[7:4] - 4'd1, 4'd9};
        end else begin
            r = {v[7:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

    state_e          state_q, state_d;
    logic [7:0]      time_q, time_d;
    logic [7:0]      hits_q, hits_d;
    logic [7:0]      goal_q, goal_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic [RW-1:0]   rcnt_q, rcnt_d;
    logic            win_q, win_d;
    logic            first_q, first_d;

    logic [7:0]      time_clamped;
    logic [7:0]      goal_clamped;
    logic            timed_state;
    logic            goal_met;
    logic            time_out;

    assign time_clamped = clamp_bcd(time_cfg);
    assign goal_clamped = clamp_bcd(goal_cfg);
    assign timed_state  = (state_q == S_PLAY) || (state_q == S_RESULT);
    assign tick         = timed_state && (tcnt_q == TICK_LAST);
    assign goal_met     = (hits_q == goal_q);
    assign time_out     = (time_q == 8'h00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            time_q  <= 8'h00;
            hits_q  <= 8'h00;
            goal_q  <= 8'h00;
            tcnt_q  <= '0;
            rcnt_q  <= '0;
            win_q   <= 1'b0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            hits_q  <= hits_d;
            goal_q  <= goal_d;
            tcnt_q  <= tcnt_d;
            rcnt_q  <= rcnt_d;
            win_q   <= win_d;
            first_q <= first_d;
        end
    end

    // Exit test in PLAY takes precedence: the counters freeze on the exit edge.
    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        hits_d  = hits_q;
        goal_d  = goal_q;
        tcnt_d  = tcnt_q;
        rcnt_d  = rcnt_q;
        win_d   = win_q;
        first_d = 1'b0;
        spawn   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ARMED;
                end
            end

            S_ARMED: begin
                if (start) begin
                    state_d = S_PLAY;
                    time_d  = time_clamped;
                    goal_d  = goal_clamped;
                    hits_d  = 8'h00;
                    tcnt_d  = '0;
                    first_d = 1'b1;
                end
            end

            S_PLAY: begin
                spawn  = first_q;
                tcnt_d = tick ? '0 : tcnt_q + 1'b1;
                if (goal_met || time_out) begin
                    state_d = S_RESULT;
                    win_d   = goal_met;
                    tcnt_d  = '0;
                    rcnt_d  = '0;
                end else begin
                    if (tick) begin
                        spawn  = 1'b1;
                        time_d = bcd_dec(time_q);
                    end
                    if (hit) begin
                        hits_d = bcd_inc(hits_q);
                    end
                end
            end

            S_RESULT: begin
                tcnt_d = tick ? '0 : tcnt_q + 1'b1;
                if (tick) begin
                    if (rcnt_q == RES_LAST) begin
                        state_d = S_IDLE;
                        win_d   = 1'b0;
                        rcnt_d  = '0;
                    end else begin
                        rcnt_d = rcnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Before a game starts the displays preview the clamped settings.
    always_comb begin
        if (timed_state) begin
            time_bcd = time_q;
            hits_bcd = hits_q;
        end else begin
            time_bcd = time_clamped;
            hits_bcd = goal_clamped;
        end
    end

    assign state = state_q;
    assign win   = win_q;

endmodule

// File: tb/tb_game_seq_ctrl.sv
// Self-checking bench for game_seq_ctrl: directed scenarios plus randomized
// traffic compared against a decimal-arithmetic model of the game rules.
module tb_game_seq_ctrl;

    localparam int TC = 8;
    localparam int RT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       hit = 1'b0;
    logic [7:0] time_cfg = 8'h00;
    logic [7:0] goal_cfg = 8'h00;
    logic [1:0] state;
    logic [7:0] time_bcd;
    logic [7:0] hits_bcd;
    logic       spawn;
    logic       win;
    logic       tick;

    int n_checks = 0;
    int n_fail   = 0;

    game_seq_ctrl #(.TICK_CYCLES(TC), .RESULT_TICKS(RT)) dut (
        .clk(clk), .rst(rst), .start(start), .hit(hit),
        .time_cfg(time_cfg), .goal_cfg(goal_cfg),
        .state(state), .time_bcd(time_bcd), .hits_bcd(hits_bcd),
        .spawn(spawn), .win(win), .tick(tick)
    );

    always #5 clk = ~clk;

    // Behavioural model: plain decimal integers, converted to BCD only for display.
    int m_state, m_time, m_hits, m_goal, m_tc, m_rc;
    bit m_win, m_first;

    function automatic int clamp_dec(input logic [7:0] v);
        int t;
        int o;
        t = (v[7:4] > 4'd9) ? 9 : int'(v[7:4]);
        o = (v[3:0] > 4'd9) ? 9 : int'(v[3:0]);
        return t * 10 + o;
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; hit = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic go_play(input logic [7:0] t, input logic [7:0] g);
        time_cfg = t; goal_cfg = g;
        start = 1'b1; step();
        start = 1'b0; step();
        start = 1'b1; step();
        start = 1'b0;
    endtask

    task automatic model_reset();
        m_state = 0; m_time = 0; m_hits = 0; m_goal = 0;
        m_tc = 0; m_rc = 0; m_win = 1'b0; m_first = 1'b0;
    endtask

    task automatic model_step(input bit r, input bit s, input bit h,
                              input logic [7:0] tc, input logic [7:0] gc);
        bit tk;
        tk = (m_state >= 2) && (m_tc == TC - 1);
        if (r) begin
            model_reset();
            return;
        end
        case (m_state)
            0: if (s) m_state = 1;
            1: if (s) begin
                m_state = 2; m_time = clamp_dec(tc); m_goal = clamp_dec(gc);
                m_hits = 0; m_tc = 0; m_first = 1'b1;
            end
            2: begin
                m_first = 1'b0;
                if (m_hits == m_goal || m_time == 0) begin
                    m_win = (m_hits == m_goal);
                    m_state = 3; m_tc = 0; m_rc = 0;
                end else begin
                    m_tc = tk ? 0 : m_tc + 1;
                    if (tk && m_time > 0) m_time = m_time - 1;
                    if (h && m_hits < 99) m_hits = m_hits + 1;
                end
            end
            default: begin
                if (tk) begin
                    m_tc = 0;
                    if (m_rc == RT - 1) begin
                        m_state = 0; m_win = 1'b0; m_rc = 0;
                    end else begin
                        m_rc = m_rc + 1;
                    end
                end else begin
                    m_tc = m_tc + 1;
                end
            end
        endcase
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; hit = 1'b1; time_cfg = 8'h47; goal_cfg = 8'h25;
        step();
        start = 1'b0; hit = 1'b0;
        n_checks++; if (state !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_state: got %0d expected 0", state); end
        n_checks++; if (win !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_win: got %b expected 0", win); end
        n_checks++; if (spawn !== 1'b0 || tick !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_pulses: got spawn=%b tick=%b expected 0 0", spawn, tick); end
        n_checks++; if (time_bcd !== 8'h47 || hits_bcd !== 8'h25) begin n_fail++; $display("[TB] FAIL reset_preview: got %h/%h expected 47/25", time_bcd, hits_bcd); end
        rst = 1'b0;
    endtask

    task automatic test_normal_win();
        int n;
        int sp;
        int bad;
        do_reset();
        go_play(8'h05, 8'h03);
        n_checks++; if (state !== 2'd2 || spawn !== 1'b1) begin n_fail++; $display("[TB] FAIL win_entry: got state=%0d spawn=%b expected 2 1", state, spawn); end
        n_checks++; if (time_bcd !== 8'h05 || hits_bcd !== 8'h00) begin n_fail++; $display("[TB] FAIL win_load: got %h/%h expected 05/00", time_bcd, hits_bcd); end
        repeat (7) step();
        n_checks++; if (tick !== 1'b1 || spawn !== 1'b1) begin n_fail++; $display("[TB] FAIL win_tick: got tick=%b spawn=%b expected 1 1", tick, spawn); end
        step();
        n_checks++; if (time_bcd !== 8'h04 || spawn !== 1'b0) begin n_fail++; $display("[TB] FAIL win_dec: got time=%h spawn=%b expected 04 0", time_bcd, spawn); end
        hit = 1'b1;
        repeat (3) step();
        hit = 1'b0;
        n_checks++; if (state !== 2'd2 || hits_bcd !== 8'h03) begin n_fail++; $display("[TB] FAIL win_hits: got state=%0d hits=%h expected 2 03", state, hits_bcd); end
        step();
        n_checks++; if (state !== 2'd3 || win !== 1'b1 || hits_bcd !== 8'h03 || time_bcd !== 8'h04) begin
            n_fail++; $display("[TB] FAIL win_result: got state=%0d win=%b hits=%h time=%h expected 3 1 03 04", state, win, hits_bcd, time_bcd); end
        n = 1; sp = 0; bad = 0;
        start = 1'b1; hit = 1'b1;
        while (state == 2'd3 && n < 100) begin
            if (spawn) sp++;
            if (hits_bcd !== 8'h03 || time_bcd !== 8'h04 || win !== 1'b1) bad++;
            step();
            if (state == 2'd3) n++;
        end
        start = 1'b0; hit = 1'b0;
        n_checks++; if (n != 32) begin n_fail++; $display("[TB] FAIL result_len: got %0d cycles expected 32", n); end
        n_checks++; if (sp != 0 || bad != 0) begin n_fail++; $display("[TB] FAIL result_frozen: got spawns=%0d changes=%0d expected 0 0", sp, bad); end
        n_checks++; if (state !== 2'd0 || win !== 1'b0) begin n_fail++; $display("[TB] FAIL result_exit: got state=%0d win=%b expected 0 0", state, win); end
    endtask

    task automatic test_timeout();
        int k;
        int sp;
        logic [7:0] t9;
        logic [7:0] t17;
        do_reset();
        go_play(8'h02, 8'h05);
        n_checks++; if (spawn !== 1'b1) begin n_fail++; $display("[TB] FAIL to_first_spawn: got %b expected 1", spawn); end
        k = 1; sp = 0; t9 = 8'hFF; t17 = 8'hFF;
        while (state == 2'd2 && k < 60) begin
            if (spawn && k > 1) sp++;
            if (k == 9) t9 = time_bcd;
            if (k == 17) t17 = time_bcd;
            step();
            if (state == 2'd2) k++;
        end
        n_checks++; if (t9 !== 8'h01 || t17 !== 8'h00) begin n_fail++; $display("[TB] FAIL to_count: got %h,%h expected 01,00", t9, t17); end
        n_checks++; if (k != 17) begin n_fail++; $display("[TB] FAIL to_play_len: got %0d expected 17", k); end
        n_checks++; if (state !== 2'd3 || win !== 1'b0) begin n_fail++; $display("[TB] FAIL to_result: got state=%0d win=%b expected 3 0", state, win); end
        n_checks++; if (sp != 2) begin n_fail++; $display("[TB] FAIL to_spawns: got %0d expected 2", sp); end
    endtask

    task automatic test_bcd_sat();
        do_reset();
        go_play(8'h12, 8'h05);
        repeat (8) step();
        n_checks++; if (time_bcd !== 8'h11) begin n_fail++; $display("[TB] FAIL bcd_t1: got %h expected 11", time_bcd); end
        repeat (8) step();
        n_checks++; if (time_bcd !== 8'h10) begin n_fail++; $display("[TB] FAIL bcd_t2: got %h expected 10", time_bcd); end
        repeat (8) step();
        n_checks++; if (time_bcd !== 8'h09) begin n_fail++; $display("[TB] FAIL bcd_t3: got %h expected 09", time_bcd); end
        do_reset();
        go_play(8'h99, 8'h99);
        hit = 1'b1;
        repeat (9) step();
        n_checks++; if (hits_bcd !== 8'h09) begin n_fail++; $display("[TB] FAIL bcd_h9: got %h expected 09", hits_bcd); end
        step();
        n_checks++; if (hits_bcd !== 8'h10) begin n_fail++; $display("[TB] FAIL bcd_h10: got %h expected 10", hits_bcd); end
        repeat (91) step();
        hit = 1'b0;
        n_checks++; if (hits_bcd !== 8'h99 || state !== 2'd3 || win !== 1'b1) begin
            n_fail++; $display("[TB] FAIL bcd_sat: got hits=%h state=%0d win=%b expected 99 3 1", hits_bcd, state, win); end
        n_checks++; if (time_bcd !== 8'h87) begin n_fail++; $display("[TB] FAIL bcd_time99: got %h expected 87", time_bcd); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        go_play(8'h01, 8'h02);
        hit = 1'b1; step();
        hit = 1'b0; repeat (6) step();
        n_checks++; if (tick !== 1'b1 || state !== 2'd2) begin n_fail++; $display("[TB] FAIL sim_tick: got tick=%b state=%0d expected 1 2", tick, state); end
        hit = 1'b1; step();
        hit = 1'b0;
        n_checks++; if (time_bcd !== 8'h00 || hits_bcd !== 8'h02) begin n_fail++; $display("[TB] FAIL sim_both: got time=%h hits=%h expected 00 02", time_bcd, hits_bcd); end
        step();
        n_checks++; if (state !== 2'd3 || win !== 1'b1) begin n_fail++; $display("[TB] FAIL sim_win: got state=%0d win=%b expected 3 1", state, win); end
    endtask

    task automatic test_clamp_zero();
        do_reset();
        time_cfg = 8'h3F; goal_cfg = 8'hA7; #1;
        n_checks++; if (time_bcd !== 8'h39 || hits_bcd !== 8'h97) begin n_fail++; $display("[TB] FAIL clamp_preview: got %h/%h expected 39/97", time_bcd, hits_bcd); end
        go_play(8'h3F, 8'h00);
        n_checks++; if (state !== 2'd2 || time_bcd !== 8'h39 || spawn !== 1'b1) begin
            n_fail++; $display("[TB] FAIL clamp_load: got state=%0d time=%h spawn=%b expected 2 39 1", state, time_bcd, spawn); end
        step();
        n_checks++; if (state !== 2'd3 || win !== 1'b1) begin n_fail++; $display("[TB] FAIL zero_goal: got state=%0d win=%b expected 3 1", state, win); end
        do_reset();
        go_play(8'h00, 8'h05);
        step();
        n_checks++; if (state !== 2'd3 || win !== 1'b0) begin n_fail++; $display("[TB] FAIL zero_time: got state=%0d win=%b expected 3 0", state, win); end
    endtask

    task automatic test_reset_mid_play();
        do_reset();
        go_play(8'h20, 8'h07);
        hit = 1'b1; repeat (2) step();
        hit = 1'b0;
        n_checks++; if (hits_bcd !== 8'h02) begin n_fail++; $display("[TB] FAIL rmp_hits: got %h expected 02", hits_bcd); end
        rst = 1'b1; start = 1'b1; hit = 1'b1;
        step();
        rst = 1'b0; start = 1'b0; hit = 1'b0;
        n_checks++; if (state !== 2'd0 || win !== 1'b0 || spawn !== 1'b0 || tick !== 1'b0) begin
            n_fail++; $display("[TB] FAIL rmp_state: got state=%0d win=%b spawn=%b tick=%b expected 0 0 0 0", state, win, spawn, tick); end
        n_checks++; if (hits_bcd !== 8'h07 || time_bcd !== 8'h20) begin n_fail++; $display("[TB] FAIL rmp_preview: got %h/%h expected 07/20", hits_bcd, time_bcd); end
    endtask

    task automatic test_random();
        logic [7:0] e_time;
        logic [7:0] e_hits;
        bit e_tick;
        bit e_spawn;
        do_reset();
        model_reset();
        for (int c = 0; c < 1500; c++) begin
            if (c % 150 == 0) begin
                time_cfg = {4'($urandom_range(0, 1)), 4'($urandom_range(0, 15))};
                goal_cfg = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 15))};
            end
            rst   = ($urandom_range(0, 399) == 0);
            start = ($urandom_range(0, 5) == 0);
            hit   = ($urandom_range(0, 2) == 0);
            #1;
            e_tick  = (m_state >= 2) && (m_tc == TC - 1);
            e_time  = (m_state < 2) ? to_bcd(clamp_dec(time_cfg)) : to_bcd(m_time);
            e_hits  = (m_state < 2) ? to_bcd(clamp_dec(goal_cfg)) : to_bcd(m_hits);
            e_spawn = (m_state == 2) && (m_first || (e_tick && !(m_hits == m_goal || m_time == 0)));
            n_checks++; if (state !== 2'(m_state)) begin n_fail++; $display("[TB] FAIL rnd_state c=%0d: got %0d expected %0d", c, state, m_state); end
            n_checks++; if (time_bcd !== e_time) begin n_fail++; $display("[TB] FAIL rnd_time c=%0d: got %h expected %h", c, time_bcd, e_time); end
            n_checks++; if (hits_bcd !== e_hits) begin n_fail++; $display("[TB] FAIL rnd_hits c=%0d: got %h expected %h", c, hits_bcd, e_hits); end
            n_checks++; if (spawn !== e_spawn) begin n_fail++; $display("[TB] FAIL rnd_spawn c=%0d: got %b expected %b", c, spawn, e_spawn); end
            n_checks++; if (win !== m_win) begin n_fail++; $display("[TB] FAIL rnd_win c=%0d: got %b expected %b", c, win, m_win); end
            n_checks++; if (tick !== e_tick) begin n_fail++; $display("[TB] FAIL rnd_tick c=%0d: got %b expected %b", c, tick, e_tick); end
            model_step(rst, start, hit, time_cfg, goal_cfg);
            @(posedge clk);
            #1;
        end
        rst = 1'b0; start = 1'b0; hit = 1'b0;
    endtask

    initial begin
        #2;
        test_reset();
        test_normal_win();
        test_timeout();
        test_bcd_sat();
        test_simultaneous();
        test_clamp_zero();
        test_reset_mid_play();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
